fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: control, instruction-memory and decoded-output bundle of the fetch unit
interface fetch_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        int_req;
   logic [31:0] imem_addr;
   logic [15:0] imem_data;
   logic [4:0]  opcode;
   logic [2:0]  Rs;
   logic [2:0]  Rd;
   logic [4:0]  shmnt;
   logic [15:0] imm;
   logic [31:0] pc;
   logic [31:0] Next_inst_addr;
   logic        int1;
   logic        valid;
   modport master (
      input  stall, branch_taken, branch_target, int_req, imem_data,
      output imem_addr, opcode, Rs, Rd, shmnt, imm, pc, Next_inst_addr, int1, valid
   );
   modport slave (
      output stall, branch_taken, branch_target, int_req, imem_data,
      input  imem_addr, opcode, Rs, Rd, shmnt, imm, pc, Next_inst_addr, int1, valid
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: 16/32-bit instruction fetch with branch redirect, stall and interrupt-slot injection
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] INT_VECTOR = 32'h0000_0002
) (
   input logic      clk,
   input logic      rst_n,
   fetch_if.master  bus
);
   typedef enum logic {FETCH, IMM} state_t;
   state_t      r_state, w_state;
   logic [31:0] r_pc, w_pc, r_opc, w_opc, r_nia, w_nia;
   logic [15:0] r_hold, w_hold, r_inst, w_inst, r_imm, w_imm;
   logic        r_pend, w_pend, r_int1, w_int1, r_valid, w_valid;
   logic        w_long;
   assign w_long             = bus.imem_data[15:14] == 2'b11;
   assign bus.imem_addr      = r_pc;
   assign bus.opcode         = r_inst[15:11];
   assign bus.Rs             = r_inst[10:8];
   assign bus.Rd             = r_inst[7:5];
   assign bus.shmnt          = r_inst[4:0];
   assign bus.imm            = r_imm;
   assign bus.pc             = r_opc;
   assign bus.Next_inst_addr = r_nia;
   assign bus.int1           = r_int1;
   assign bus.valid          = r_valid;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_hold  <= '0;
         r_pend  <= 1'b0;
         r_inst  <= '0;
         r_imm   <= '0;
         r_opc   <= '0;
         r_nia   <= '0;
         r_int1  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state;
         r_pc    <= w_pc;
         r_hold  <= w_hold;
         r_pend  <= w_pend;
         r_inst  <= w_inst;
         r_imm   <= w_imm;
         r_opc   <= w_opc;
         r_nia   <= w_nia;
         r_int1  <= w_int1;
         r_valid <= w_valid;
      end
   always_comb begin
      w_state = r_state;
      w_pc    = r_pc;
      w_hold  = r_hold;
      w_pend  = r_pend | bus.int_req;
      w_inst  = r_inst;
      w_imm   = r_imm;
      w_opc   = r_opc;
      w_nia   = r_nia;
      w_int1  = r_int1;
      w_valid = r_valid;
      if (bus.branch_taken) begin
         w_pc    = bus.branch_target;
         w_state = FETCH;
         w_hold  = '0;
         w_valid = 1'b0;
         w_int1  = 1'b0;
      end else if (!bus.stall) begin
         // interrupts are only taken at FETCH so a held first word is never orphaned
         if (r_state == IMM) begin
            w_inst  = r_hold;
            w_imm   = bus.imem_data;
            w_opc   = r_pc - 32'd1;
            w_nia   = r_pc + 32'd1;
            w_valid = 1'b1;
            w_int1  = 1'b0;
            w_pc    = r_pc + 32'd1;
            w_hold  = '0;
            w_state = FETCH;
         end else if (r_pend) begin
            w_inst  = '0;
            w_imm   = '0;
            w_opc   = r_pc;
            w_nia   = r_pc;
            w_valid = 1'b1;
            w_int1  = 1'b1;
            w_pc    = INT_VECTOR;
            w_pend  = bus.int_req;
         end else if (w_long) begin
            w_hold  = bus.imem_data;
            w_valid = 1'b0;
            w_int1  = 1'b0;
            w_pc    = r_pc + 32'd1;
            w_state = IMM;
         end else begin
            w_inst  = bus.imem_data;
            w_imm   = '0;
            w_opc   = r_pc;
            w_nia   = r_pc + 32'd1;
            w_valid = 1'b1;
            w_int1  = 1'b0;
            w_pc    = r_pc + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit against a small instruction memory
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [15:0] mem [128];
   fetch_if bus ();
   fetch_unit #(.RESET_PC(32'h0), .INT_VECTOR(32'h2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.imem_data = mem[bus.imem_addr[6:0]];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'h0800;
      mem[0]   = 16'h0A41;
      mem[1]   = 16'hC123;
      mem[2]   = 16'hBEEF;
      mem[64]  = 16'h1234;
      mem[127] = 16'h2000;
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = '0;
      bus.int_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(bus.valid), 0);
      check("rst_int1", 32'(bus.int1), 0);
      check("rst_addr", bus.imem_addr, 0);
      check("rst_pc", bus.pc, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      check("s16_opcode", 32'(bus.opcode), 32'h01);
      check("s16_rs", 32'(bus.Rs), 2);
      check("s16_rd", 32'(bus.Rd), 2);
      check("s16_shmnt", 32'(bus.shmnt), 1);
      check("s16_pc", bus.pc, 0);
      check("s16_nia", bus.Next_inst_addr, 1);
      check("s16_valid", 32'(bus.valid), 1);
      check("s16_imm", 32'(bus.imm), 0);
      step();
      check("l32_bubble", 32'(bus.valid), 0);
      check("l32_addr", bus.imem_addr, 2);
      bus.int_req = 1'b1;
      step();
      bus.int_req = 1'b0;
      check("l32_valid", 32'(bus.valid), 1);
      check("l32_opcode", 32'(bus.opcode), 32'h18);
      check("l32_rs", 32'(bus.Rs), 1);
      check("l32_rd", 32'(bus.Rd), 1);
      check("l32_shmnt", 32'(bus.shmnt), 3);
      check("l32_imm", 32'(bus.imm), 32'hBEEF);
      check("l32_pc", bus.pc, 1);
      check("l32_nia", bus.Next_inst_addr, 3);
      check("l32_int1", 32'(bus.int1), 0);
      step();
      check("int_int1", 32'(bus.int1), 1);
      check("int_valid", 32'(bus.valid), 1);
      check("int_pc", bus.pc, 3);
      check("int_nia", bus.Next_inst_addr, 3);
      check("int_opcode", 32'(bus.opcode), 0);
      check("int_imm", 32'(bus.imm), 0);
      check("int_addr", bus.imem_addr, 2);
      step();
      check("vec_int1", 32'(bus.int1), 0);
      check("vec_opcode", 32'(bus.opcode), 32'h17);
      check("vec_rd", 32'(bus.Rd), 7);
      check("vec_shmnt", 32'(bus.shmnt), 32'h0F);
      check("vec_pc", bus.pc, 2);
      bus.stall = 1'b1;
      step();
      check("stl_valid", 32'(bus.valid), 1);
      check("stl_pc", bus.pc, 2);
      check("stl_addr", bus.imem_addr, 3);
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h40;
      step();
      bus.branch_taken = 1'b0;
      check("sbr_valid", 32'(bus.valid), 0);
      check("sbr_addr", bus.imem_addr, 32'h40);
      step();
      check("sbr_hold_valid", 32'(bus.valid), 0);
      check("sbr_hold_addr", bus.imem_addr, 32'h40);
      bus.stall = 1'b0;
      step();
      check("t40_opcode", 32'(bus.opcode), 2);
      check("t40_shmnt", 32'(bus.shmnt), 32'h14);
      check("t40_pc", bus.pc, 32'h40);
      check("t40_nia", bus.Next_inst_addr, 32'h41);
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'hFFFF_FFFF;
      step();
      bus.branch_taken = 1'b0;
      check("wbr_valid", 32'(bus.valid), 0);
      check("wbr_addr", bus.imem_addr, 32'hFFFF_FFFF);
      step();
      check("wrap_opcode", 32'(bus.opcode), 4);
      check("wrap_pc", bus.pc, 32'hFFFF_FFFF);
      check("wrap_nia", bus.Next_inst_addr, 0);
      check("wrap_addr", bus.imem_addr, 0);
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h1;
      step();
      bus.branch_taken = 1'b0;
      step();
      check("mid_bubble", 32'(bus.valid), 0);
      check("mid_addr", bus.imem_addr, 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_opcode", 32'(bus.opcode), 0);
      check("arst_pc", bus.pc, 0);
      check("arst_nia", bus.Next_inst_addr, 0);
      check("arst_valid", 32'(bus.valid), 0);
      check("arst_addr", bus.imem_addr, 0);
      #1 rst_n = 1'b1;
      step();
      check("post_valid", 32'(bus.valid), 1);
      check("post_pc", bus.pc, 0);
      check("post_opcode", 32'(bus.opcode), 1);
      check("post_imm", 32'(bus.imm), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
